// File: rtl/edge_detect_bank.sv
// edge_detect_bank: multi-channel synchronising edge detector.
// Each channel runs the raw input through a synchroniser chain and an optional
// debounce filter. It then produces 1-cycle rise/fall pulses, a mode-qualified
// event pulse, and sticky pending/overflow flags.
// Optional feature: define EDGE_DEBOUNCE_EN to insert a DB_CYCLES stability filter
// between the synchroniser and the edge detector. When the macro is undefined,
// the filtered value is the synchroniser output itself.
module edge_detect_bank #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   d_in,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   clr,
    output logic [N_CH-1:0]   rise_p,
    output logic [N_CH-1:0]   fall_p,
    output logic [N_CH-1:0]   evt_p,
    output logic [N_CH-1:0]   pending,
    output logic [N_CH-1:0]   overflow,
    output logic              any_pending
);

    // Bit [0] is the newest sample; bit [SYNC_STAGES-1] is the synchronised value.
    logic [SYNC_STAGES-1:0] r_sync [N_CH];
    logic [N_CH-1:0]        w_s;
    logic [N_CH-1:0]        w_filt;
    logic [N_CH-1:0]        r_prev;
    logic [N_CH-1:0]        r_pending;
    logic [N_CH-1:0]        r_overflow;
    logic [N_CH-1:0]        w_rise;
    logic [N_CH-1:0]        w_fall;
    logic [N_CH-1:0]        w_evt;

    // Synchroniser chains; reset flushes any edge still in flight.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (reset) r_sync[c] <= '0;
            else       r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], d_in[c]};
        end
    end

    // Tap the last synchroniser stage of every channel.
    always_comb begin
        w_s = '0;
        for (int c = 0; c < N_CH; c++) w_s[c] = r_sync[c][SYNC_STAGES-1];
    end

`ifdef EDGE_DEBOUNCE_EN
    localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt [N_CH];
    logic [N_CH-1:0]  r_filt;

    // Debounce: the filtered value follows s only after DB_CYCLES consecutive
    // disagreeing samples; any return to the filtered value restarts the count.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (reset) begin
                r_cnt[c]  <= '0;
                r_filt[c] <= 1'b0;
            end else if (w_s[c] == r_filt[c]) begin
                r_cnt[c] <= '0;
            end else if (r_cnt[c] == CNT_LAST) begin
                r_filt[c] <= w_s[c];
                r_cnt[c]  <= '0;
            end else begin
                r_cnt[c] <= r_cnt[c] + 1'b1;
            end
        end
    end

    assign w_filt = r_filt;
`else
    // Without debounce the filtered value is the synchroniser output, adding no delay.
    assign w_filt = w_s;
`endif

    // Edge pulses and mode qualification, combinational from registered state.
    // NOTE: always_comb assigns every output a default first, so no latch can be inferred.
    always_comb begin
        w_rise = w_filt & ~r_prev;
        w_fall = ~w_filt & r_prev;
        w_evt  = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_evt[c] = (w_rise[c] & mode[2*c]) | (w_fall[c] & mode[2*c+1]);
        end
    end

    // Previous filtered value and the sticky pending/overflow flags.
    // A same-cycle event beats clr for pending; clr always blocks a new overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= '0;
            r_pending  <= '0;
            r_overflow <= '0;
        end else begin
            r_prev     <= w_filt;
            r_pending  <= (r_pending & ~clr) | w_evt;
            r_overflow <= (r_overflow & ~clr) | (w_evt & r_pending & ~clr);
        end
    end

    assign rise_p      = w_rise;
    assign fall_p      = w_fall;
    assign evt_p       = w_evt;
    assign pending     = r_pending;
    assign overflow    = r_overflow;
    assign any_pending = |r_pending;

endmodule
